// File: rtl/game_pkg.sv
// Shared state encoding and widths for the game flow controller and its pixel hit counter.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_CRASH     = 3'd3,
        ST_GAME_OVER = 3'd4
    } game_state_t;

    localparam int FRAME_LINE_DEFAULT = 515;
    localparam int LIVES_W            = 2;
    localparam int HIT_W              = 10;
    localparam int TICK_W             = 8;
    localparam logic [1:0] DIGIT_START = 2'd3;

endpackage

// File: rtl/game_flow_controller_pixel_hit_counter.sv
// Counts player/off-road overlap clocks per frame and flags a crash candidate at end of frame.
module pixel_hit_counter
    import game_pkg::*;
#(
    parameter int FRAME_LINE = FRAME_LINE_DEFAULT,
    parameter int HIT_THRESH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] vCount,
    input  logic       bright,
    input  logic       player_px,
    input  logic       offroad_px,
    output logic       crash_cand
);

    logic             line_hit;
    logic             fl_q;
    logic             frame_end;
    logic [HIT_W-1:0] hit_cnt;

    assign line_hit   = (vCount == 10'(FRAME_LINE));
    assign frame_end  = line_hit & ~fl_q;
    // Threshold uses the count before the end-of-frame clear takes effect.
    assign crash_cand = frame_end & (hit_cnt >= HIT_W'(HIT_THRESH));

    always_ff @(posedge clk) begin
        if (rst) begin
            fl_q    <= 1'b0;
            hit_cnt <= '0;
        end else begin
            fl_q <= line_hit;
            if (frame_end)
                hit_cnt <= '0;
            else if (bright & player_px & offroad_px & (hit_cnt != '1))
                hit_cnt <= hit_cnt + HIT_W'(1);
        end
    end

endmodule

// File: rtl/game_flow_controller.sv
// Session sequencer: IDLE -> COUNTDOWN -> PLAY -> CRASH -> (COUNTDOWN | GAME_OVER).
module game_flow_controller
    import game_pkg::*;
#(
    parameter int LIVES_INIT  = 3,
    parameter int COUNT_TICKS = 32,
    parameter int CRASH_TICKS = 48,
    parameter int HIT_THRESH  = 16,
    parameter int FRAME_LINE  = FRAME_LINE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_start,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic       bright,
    input  logic       player_px,
    input  logic       offroad_px,
    output logic [2:0] state,
    output logic       run_en,
    output logic       world_rst,
    output logic       dead,
    output logic [1:0] lives,
    output logic [1:0] count_digit,
    output logic       flash
);

    localparam logic [TICK_W-1:0]  COUNT_LAST  = TICK_W'(COUNT_TICKS - 1);
    localparam logic [TICK_W-1:0]  CRASH_LAST  = TICK_W'(CRASH_TICKS - 1);
    localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(LIVES_INIT);

    game_state_t        state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [1:0]         digit_q, digit_d;
    logic               wrst_q, wrst_d;
    logic               btn_q;
    logic               start_pulse;
    logic               crash_cand;
    logic               crash_evt;
    logic               unused_hcount;

    // Overlap is counted per clock, so the horizontal position is not needed.
    assign unused_hcount = ^hCount;

    pixel_hit_counter #(
        .FRAME_LINE (FRAME_LINE),
        .HIT_THRESH (HIT_THRESH)
    ) u_hits (
        .clk        (clk),
        .rst        (rst),
        .vCount     (vCount),
        .bright     (bright),
        .player_px  (player_px),
        .offroad_px (offroad_px),
        .crash_cand (crash_cand)
    );

    // Tracking the button even during reset means a press held through reset release is not a new press.
    always_ff @(posedge clk) begin
        btn_q <= btn_start;
    end

    assign start_pulse = btn_start & ~btn_q;
    assign crash_evt   = crash_cand & (state_q == ST_PLAY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            lives_q <= LIVES_START;
            digit_q <= 2'd0;
            wrst_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            lives_q <= lives_d;
            digit_q <= digit_d;
            wrst_q  <= wrst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        lives_d = lives_q;
        digit_d = digit_q;
        wrst_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_d = ST_COUNTDOWN;
                    lives_d = LIVES_START;
                    tick_d  = '0;
                    digit_d = DIGIT_START;
                    wrst_d  = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    if (tick_q == COUNT_LAST) begin
                        tick_d = '0;
                        if (digit_q == 2'd1) begin
                            state_d = ST_PLAY;
                            digit_d = 2'd0;
                        end else begin
                            digit_d = digit_q - 2'd1;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (crash_evt) begin
                    state_d = ST_CRASH;
                    tick_d  = '0;
                    if (lives_q != '0)
                        lives_d = lives_q - LIVES_W'(1);
                end
            end
            ST_CRASH: begin
                if (tick) begin
                    if (tick_q == CRASH_LAST) begin
                        tick_d = '0;
                        if (lives_q != '0) begin
                            state_d = ST_COUNTDOWN;
                            digit_d = DIGIT_START;
                            wrst_d  = 1'b1;
                        end else begin
                            state_d = ST_GAME_OVER;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            ST_GAME_OVER: begin
                if (start_pulse)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
                digit_d = 2'd0;
            end
        endcase
    end

    assign state       = state_q;
    assign run_en      = (state_q == ST_PLAY);
    assign dead        = (state_q == ST_GAME_OVER);
    assign flash       = (state_q == ST_CRASH) & tick_q[2];
    assign world_rst   = wrst_q;
    assign lives       = lives_q;
    assign count_digit = digit_q;

endmodule
